// File: rtl/instr_encoder.sv
// RV64 instruction encoder: packs format fields into a 32-bit word and queues it in an output FIFO.
// Optional decode-back self-check is enabled by defining INSTR_ENC_SELF_CHECK_EN.

`ifdef INSTR_ENC_SELF_CHECK_EN
module instr_enc_decoder (
    input  logic [31:0] word,
    input  logic [2:0]  fmt,
    output logic [6:0]  op,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [63:0] imm
);
    assign op  = word[6:0];
    assign rd  = word[11:7];
    assign f3  = word[14:12];
    assign rs1 = word[19:15];
    assign rs2 = word[24:20];
    assign f7  = word[31:25];

    // U immediates are zero-extended to match the encoder's range rule
    always_comb begin
        imm = '0;
        case (fmt)
            3'd1:    imm = {{52{word[31]}}, word[31:20]};
            3'd2:    imm = {{52{word[31]}}, word[31:25], word[11:7]};
            3'd3:    imm = {{51{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
            3'd4:    imm = {32'b0, word[31:12], 12'b0};
            3'd5:    imm = {{43{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule
`endif

module instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [63:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic        selfchk_fail_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
        FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
    } fmt_t;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        ok11, ok12, ok20;
    logic        push, pop;

    logic [31:0] mem_word [FIFO_DEPTH];
    logic        mem_err  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Each flag: the upper immediate bits are a pure sign extension
    assign ok11 = (&imm_i[63:11]) | ~(|imm_i[63:11]);
    assign ok12 = (&imm_i[63:12]) | ~(|imm_i[63:12]);
    assign ok20 = (&imm_i[63:20]) | ~(|imm_i[63:20]);

    always_comb begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
        case (fmt_i)
            FMT_R: begin
                enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
                enc_err  = 1'b0;
            end
            FMT_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                enc_err  = ~ok11;
            end
            FMT_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                enc_err  = ~ok11;
            end
            FMT_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
                enc_err  = ~ok12 | imm_i[0];
            end
            FMT_U: begin
                enc_word = {imm_i[31:12], rd_i, op_i};
                enc_err  = (|imm_i[63:32]) | (|imm_i[11:0]);
            end
            FMT_J: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                enc_err  = ~ok20 | imm_i[0];
            end
            default: ;
        endcase
        if (op_i[1:0] != 2'b11)
            enc_err = 1'b1;
    end

    assign req_ready_o   = (count < DEPTH_CNT);
    assign instr_valid_o = (count != '0);
    assign push = req_valid_i && req_ready_o;
    assign pop  = instr_valid_o && instr_ready_i;
    assign instr_o = instr_valid_o ? mem_word[rd_ptr] : '0;
    assign err_o   = instr_valid_o ? mem_err[rd_ptr]  : 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_word[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_word[wr_ptr] <= enc_word;
                mem_err[wr_ptr]  <= enc_err;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef INSTR_ENC_SELF_CHECK_EN
    logic [6:0]  dec_op, dec_f7;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [2:0]  dec_f3;
    logic [63:0] dec_imm;
    logic        chk_bad;
    logic        selfchk_fail;

    instr_enc_decoder u_dec (
        .word (enc_word),
        .fmt  (fmt_i),
        .op   (dec_op),
        .rd   (dec_rd),
        .rs1  (dec_rs1),
        .rs2  (dec_rs2),
        .f3   (dec_f3),
        .f7   (dec_f7),
        .imm  (dec_imm)
    );

    // Only fields physically present in the format are compared
    always_comb begin
        chk_bad = (dec_op != op_i);
        case (fmt_i)
            FMT_R: chk_bad = chk_bad | (dec_rd != rd_i) | (dec_rs1 != rs1_i) |
                             (dec_rs2 != rs2_i) | (dec_f3 != funct3_i) | (dec_f7 != funct7_i);
            FMT_I: chk_bad = chk_bad | (dec_rd != rd_i) | (dec_rs1 != rs1_i) |
                             (dec_f3 != funct3_i) | (dec_imm != imm_i);
            FMT_S, FMT_B: chk_bad = chk_bad | (dec_rs1 != rs1_i) | (dec_rs2 != rs2_i) |
                             (dec_f3 != funct3_i) | (dec_imm != imm_i);
            FMT_U, FMT_J: chk_bad = chk_bad | (dec_rd != rd_i) | (dec_imm != imm_i);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            selfchk_fail <= 1'b0;
        else if (push && !enc_err && chk_bad)
            selfchk_fail <= 1'b1;
    end

    assign selfchk_fail_o = selfchk_fail;
`else
    assign selfchk_fail_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases, backpressure, reset flush, random traffic.
module tb_instr_encoder;
    typedef longint unsigned u64;
    localparam int DEPTH = 2;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [2:0]  fmt;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic        instr_valid, instr_ready, err, selfchk_fail;
    logic [31:0] instr;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] q[$];

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .fmt_i          (fmt),
        .op_i           (op),
        .rd_i           (rd),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .funct3_i       (f3),
        .funct7_i       (f7),
        .imm_i          (imm),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .instr_o        (instr),
        .err_o          (err),
        .selfchk_fail_o (selfchk_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: {err, word} computed arithmetically from the field rules
    function automatic logic [32:0] model(input logic [2:0] mf, input logic [6:0] mop,
            input logic [4:0] mrd, input logic [4:0] mrs1, input logic [4:0] mrs2,
            input logic [2:0] mf3, input logic [6:0] mf7, input logic [63:0] mimm);
        longint s = signed'(mimm);
        u64 u = mimm;
        u64 w;
        bit e;
        case (mf)
            3'd0: begin
                w = (u64'(mf7) << 25) + (u64'(mrs2) << 20) + (u64'(mrs1) << 15)
                  + (u64'(mf3) << 12) + (u64'(mrd) << 7) + u64'(mop);
                e = 0;
            end
            3'd1: begin
                w = ((u & 'hFFF) << 20) + (u64'(mrs1) << 15) + (u64'(mf3) << 12)
                  + (u64'(mrd) << 7) + u64'(mop);
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((u >> 5) & 'h7F) << 25) + (u64'(mrs2) << 20) + (u64'(mrs1) << 15)
                  + (u64'(mf3) << 12) + ((u & 'h1F) << 7) + u64'(mop);
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((u >> 12) & 1) << 31) + (((u >> 5) & 'h3F) << 25) + (u64'(mrs2) << 20)
                  + (u64'(mrs1) << 15) + (u64'(mf3) << 12) + (((u >> 1) & 'hF) << 8)
                  + (((u >> 11) & 1) << 7) + u64'(mop);
                e = (s < -4096) || (s > 4095) || (u % 2 != 0);
            end
            3'd4: begin
                w = (u & 'hFFFF_F000) + (u64'(mrd) << 7) + u64'(mop);
                e = (u > 'hFFFF_FFFF) || (u % 4096 != 0);
            end
            3'd5: begin
                w = (((u >> 20) & 1) << 31) + (((u >> 1) & 'h3FF) << 21) + (((u >> 11) & 1) << 20)
                  + (((u >> 12) & 'hFF) << 12) + (u64'(mrd) << 7) + u64'(mop);
                e = (s < -1048576) || (s > 1048575) || (u % 2 != 0);
            end
            default: begin
                w = 'h13;
                e = 1;
            end
        endcase
        if (mop % 4 != 3)
            e = 1;
        return {e, w[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [32:0] head;
        if (rst) begin
            q.delete();
        end else begin
            check("valid", 64'(instr_valid), 64'(q.size() != 0));
            check("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
            check("selfchk", 64'(selfchk_fail), 64'(0));
            if (q.size() != 0) begin
                head = q[0];
                check("head_word", 64'(instr), 64'(head[31:0]));
                check("head_err", 64'(err), 64'(head[32]));
                if (instr_valid && instr_ready)
                    void'(q.pop_front());
            end
            if (req_valid && req_ready)
                q.push_back(model(fmt, op, rd, rs1, rs2, f3, f7, imm));
        end
    end

    task automatic set_req(input logic [2:0] a_fmt, input logic [6:0] a_op, input logic [4:0] a_rd,
            input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [2:0] a_f3,
            input logic [63:0] a_imm);
        fmt = a_fmt; op = a_op; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; f3 = a_f3; imm = a_imm;
        f7 = 7'h20;
    endtask

    // Holds the current request until accepted; returns at posedge+1 after the accepting edge
    task automatic send(input int budget);
        bit acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout: request not accepted within %0d cycles", budget);
        end
    endtask

    task automatic direct(input string tag, input logic [31:0] exp_word, input bit chk_word,
            input bit exp_err);
        instr_ready = 1'b0;
        send(5);
        check({tag, "_valid"}, 64'(instr_valid), 64'(1));
        if (chk_word)
            check({tag, "_word"}, 64'(instr), 64'(exp_word));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
    endtask

    function automatic logic [63:0] rand_imm();
        logic [63:0] pick[12] = '{64'd2047, 64'd2048, -64'd2048, -64'd2049, 64'd4094, 64'd4096,
                                  -64'd4096, 64'd1048574, 64'd1048576, -64'd1048576,
                                  64'h1_0000_0000, 64'h8000_0000};
        case ($urandom_range(0, 4))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 10000)) - 64'd5000;
            2: return pick[$urandom_range(0, 11)];
            3: return {32'b0, $urandom & 32'hFFFF_F000};
            default: return 64'($urandom_range(0, 4000000)) - 64'd2000000;
        endcase
    endfunction

    initial begin
        logic [32:0] exp_c;
        rst = 1'b1;
        req_valid = 1'b0;
        instr_ready = 1'b0;
        set_req(3'd0, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_word", 64'(instr), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_selfchk", 64'(selfchk_fail), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(1));

        set_req(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, -64'd1);
        direct("i_fmt", 32'hFFF3_0293, 1, 0);
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 64'd8);
        direct("b_fmt", 32'h0020_8463, 1, 0);
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 64'd7);
        direct("b_odd", 32'h0, 0, 1);
        set_req(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1234_5000);
        direct("u_fmt", 32'h1234_50B7, 1, 0);
        set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 64'h800);
        direct("j_fmt", 32'h0010_00EF, 1, 0);
        set_req(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 64'd2048);
        direct("i_range", 32'h0, 0, 1);
        set_req(3'd7, 7'h33, 5'd9, 5'd3, 5'd4, 3'd1, 64'd0);
        direct("bad_fmt", 32'h0000_0013, 1, 1);
        set_req(3'd0, 7'h31, 5'd2, 5'd3, 5'd4, 3'd0, 64'd0);
        direct("bad_op", 32'h0, 0, 1);

        // Backpressure: two accepted, third held until the first pop frees a slot
        instr_ready = 1'b0;
        set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 64'd1);
        send(5);
        set_req(3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 64'd2);
        send(5);
        check("bp_full", 64'(req_ready), 64'(0));
        set_req(3'd1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 64'd3);
        exp_c = model(fmt, op, rd, rs1, rs2, f3, f7, imm);
        req_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("bp_still_full", 64'(req_ready), 64'(0));
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after_pop", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_third_head", 64'(instr), 64'(exp_c[31:0]));
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        check("bp_drained", 64'(instr_valid), 64'(0));

        // Reset flush with two entries queued
        set_req(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 64'd0);
        send(5);
        set_req(3'd4, 7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 64'h7000);
        send(5);
        check("flush_pre_valid", 64'(instr_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("flush_valid", 64'(instr_valid), 64'(0));
        check("flush_word", 64'(instr), 64'(0));
        check("flush_err", 64'(err), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("flush_ready", 64'(req_ready), 64'(1));
        check("flush_no_stale", 64'(instr_valid), 64'(0));
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_selfchk", 64'(selfchk_fail), 64'(0));

        // Random traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            fmt = 3'($urandom_range(0, 7));
            op  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            f3 = 3'($urandom); f7 = 7'($urandom);
            imm = rand_imm();
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        instr_ready = 1'b1;
        begin
            int n = 0;
            while (instr_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("final_empty", 64'(instr_valid), 64'(0));
        check("final_selfchk", 64'(selfchk_fail), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
